// File: rtl/pdn_pkg.sv
// ---------------------------------------------------------------------------
// pdn_pkg
// Shared types and helpers for the power-domain sequencer.
//   pdn_seq_state_e : sequencer FSM states
//   pdn_dir_e       : scan direction for next_set_bit
//   pdn_next_t      : {found, index} result of a mask scan
//   next_set_bit()  : nearest set bit of a mask at or beyond a start index
// Defaults for the settle and timeout intervals live here so that the top
// level and any wrapper agree on them.
// ---------------------------------------------------------------------------
package pdn_pkg;

  localparam int SETTLE_DEFAULT  = 16;
  localparam int TIMEOUT_DEFAULT = 256;

  // Mask scans are done on a fixed-width vector; the sequencer supports up
  // to MAX_DOMAINS domains and zero-extends its own mask into this width.
  localparam int MAX_DOMAINS = 32;
  localparam int MAX_IDX_W   = 5;

  typedef enum logic [3:0] {
    ST_OFF       = 4'd0,
    ST_UP_CMD    = 4'd1,
    ST_UP_WAIT   = 4'd2,
    ST_UP_SETTLE = 4'd3,
    ST_ON        = 4'd4,
    ST_DN_CMD    = 4'd5,
    ST_DN_WAIT   = 4'd6,
    ST_DN_SETTLE = 4'd7,
    ST_FAULT     = 4'd8
  } pdn_seq_state_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } pdn_dir_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] index;
  } pdn_next_t;

  // Nearest set bit of 'mask' starting at 'start' (inclusive).
  // DIR_UP returns the lowest set bit >= start, DIR_DOWN the highest set
  // bit <= start. A start outside 0..MAX_DOMAINS-1 simply finds nothing on
  // that side, which is how callers ask for "strictly above/below idx".
  function automatic pdn_next_t next_set_bit(input logic [MAX_DOMAINS-1:0] mask,
                                             input int                     start,
                                             input pdn_dir_e               dir);
    pdn_next_t r;
    r.found = 1'b0;
    r.index = '0;
    if (dir == DIR_UP) begin
      // Walk downwards so the last hit is the lowest qualifying bit.
      for (int i = MAX_DOMAINS - 1; i >= 0; i--) begin
        if (i >= start && mask[i]) begin
          r.found = 1'b1;
          r.index = MAX_IDX_W'(i);
        end
      end
    end else begin
      // Walk upwards so the last hit is the highest qualifying bit.
      for (int i = 0; i < MAX_DOMAINS; i++) begin
        if (i <= start && mask[i]) begin
          r.found = 1'b1;
          r.index = MAX_IDX_W'(i);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pdn_seq_timer.sv
// ---------------------------------------------------------------------------
// pdn_seq_timer
// Saturating up-counter with synchronous clear and a terminal-count flag.
// One instance is shared by the WAIT (ack timeout) and SETTLE intervals of
// the sequencer; the owner selects the limit for the current state.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : load zero on the next edge (has priority over counting)
//   limit    : terminal count to compare against
//   tc       : high while the count has reached 'limit'
// ---------------------------------------------------------------------------
module pdn_seq_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != {CNT_W{1'b1}}) begin
      // Hold at all-ones instead of wrapping back to zero.
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt >= limit);

endmodule

// File: rtl/pdn_domain_sequencer.sv
// ---------------------------------------------------------------------------
// pdn_domain_sequencer
// Powers NUM_DOMAINS header-switched supply domains up in ascending index
// order and down in descending order. Each step commands one switch, waits
// for its acknowledge (bounded by TIMEOUT_CYCLES) and then waits
// SETTLE_CYCLES before touching the next domain. A timeout drops every
// switch at once and parks the sequencer in a sticky FAULT state.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   pwr_up_req   : pulse, start power-up (only honoured in OFF)
//   pwr_dn_req   : pulse, start power-down from ON or abort a power-up
//   domain_mask  : domains taking part, captured when power-up starts
//   sw_ack       : per-domain rail status, already synchronous to clk
//   clear_fault  : pulse, leave FAULT for OFF
//   sw_en        : registered switch enables
//   busy         : a sequence is in progress
//   all_on       : sequencer is in ON
//   all_off      : sequencer is in OFF
//   fault        : sticky timeout flag
//   fault_dom    : index of the domain that last timed out
// NUM_DOMAINS may be 1..MAX_DOMAINS (32).
// ---------------------------------------------------------------------------
module pdn_domain_sequencer
  import pdn_pkg::*;
#(
  parameter int NUM_DOMAINS    = 6,
  parameter int SETTLE_CYCLES  = SETTLE_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + SETTLE_CYCLES + 1),
  localparam int IDX_W         = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pwr_up_req,
  input  logic                   pwr_dn_req,
  input  logic [NUM_DOMAINS-1:0] domain_mask,
  input  logic [NUM_DOMAINS-1:0] sw_ack,
  input  logic                   clear_fault,
  output logic [NUM_DOMAINS-1:0] sw_en,
  output logic                   busy,
  output logic                   all_on,
  output logic                   all_off,
  output logic                   fault,
  output logic [IDX_W-1:0]       fault_dom
);

  pdn_seq_state_e         state;
  logic [NUM_DOMAINS-1:0] mask_q;
  logic [IDX_W-1:0]       idx;

  logic [MAX_DOMAINS-1:0] req_mask_ext;
  logic [MAX_DOMAINS-1:0] mask_ext;
  pdn_next_t              nb_first;
  pdn_next_t              nb_up;
  pdn_next_t              nb_dn;
  pdn_next_t              nb_hi;
  pdn_next_t              nb_abort;

  logic                   ack_idx;
  logic                   en_idx;
  logic                   tmr_clr;
  logic [CNT_W-1:0]       tmr_limit;
  logic                   tmr_tc;

  localparam logic [CNT_W-1:0] WAIT_LIMIT   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LIMIT = CNT_W'(SETTLE_CYCLES - 1);

  assign req_mask_ext = MAX_DOMAINS'(domain_mask);
  assign mask_ext     = MAX_DOMAINS'(mask_q);

  assign ack_idx = sw_ack[idx];
  assign en_idx  = sw_en[idx];

  // Candidate next domains for every transition the FSM can take.
  assign nb_first = next_set_bit(req_mask_ext, 0, DIR_UP);
  assign nb_up    = next_set_bit(mask_ext, int'(idx) + 1, DIR_UP);
  assign nb_dn    = next_set_bit(mask_ext, int'(idx) - 1, DIR_DOWN);
  assign nb_hi    = next_set_bit(mask_ext, NUM_DOMAINS - 1, DIR_DOWN);

  // An abort unwinds from the current domain if its switch is already on;
  // in the UP_CMD cycle the switch is still off, so start one lower.
  always_comb begin
    if (en_idx) begin
      nb_abort.found = 1'b1;
      nb_abort.index = MAX_IDX_W'(idx);
    end else begin
      nb_abort = nb_dn;
    end
  end

  // The timer runs only while waiting for the ack or settling; every other
  // cycle (including the ack cycle itself) restarts it from zero so each
  // interval begins at count 0.
  always_comb begin
    tmr_clr   = 1'b1;
    tmr_limit = SETTLE_LIMIT;
    case (state)
      ST_UP_WAIT: begin
        tmr_clr   = ack_idx;
        tmr_limit = WAIT_LIMIT;
      end
      ST_DN_WAIT: begin
        tmr_clr   = !ack_idx;
        tmr_limit = WAIT_LIMIT;
      end
      ST_UP_SETTLE, ST_DN_SETTLE: begin
        tmr_clr   = 1'b0;
        tmr_limit = SETTLE_LIMIT;
      end
      default: begin
        tmr_clr   = 1'b1;
        tmr_limit = SETTLE_LIMIT;
      end
    endcase
  end

  pdn_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .limit (tmr_limit),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_OFF;
      mask_q    <= '0;
      idx       <= '0;
      sw_en     <= '0;
      fault     <= 1'b0;
      fault_dom <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          // A simultaneous down request cancels the up request here.
          if (pwr_up_req && !pwr_dn_req) begin
            mask_q <= domain_mask;
            if (nb_first.found) begin
              idx   <= IDX_W'(nb_first.index);
              state <= ST_UP_CMD;
            end else begin
              state <= ST_ON;
            end
          end
        end

        ST_UP_CMD, ST_UP_WAIT, ST_UP_SETTLE: begin
          if (pwr_dn_req) begin
            if (nb_abort.found) begin
              idx   <= IDX_W'(nb_abort.index);
              state <= ST_DN_CMD;
            end else begin
              state <= ST_OFF;
            end
          end else if (state == ST_UP_CMD) begin
            sw_en[idx] <= 1'b1;
            state      <= ST_UP_WAIT;
          end else if (state == ST_UP_WAIT) begin
            if (ack_idx) begin
              state <= ST_UP_SETTLE;
            end else if (tmr_tc) begin
              sw_en     <= '0;
              fault     <= 1'b1;
              fault_dom <= idx;
              state     <= ST_FAULT;
            end
          end else if (tmr_tc) begin
            if (nb_up.found) begin
              idx   <= IDX_W'(nb_up.index);
              state <= ST_UP_CMD;
            end else begin
              state <= ST_ON;
            end
          end
        end

        ST_ON: begin
          if (pwr_dn_req) begin
            if (nb_hi.found) begin
              idx   <= IDX_W'(nb_hi.index);
              state <= ST_DN_CMD;
            end else begin
              state <= ST_OFF;
            end
          end
        end

        ST_DN_CMD: begin
          sw_en[idx] <= 1'b0;
          state      <= ST_DN_WAIT;
        end

        ST_DN_WAIT: begin
          if (!ack_idx) begin
            state <= ST_DN_SETTLE;
          end else if (tmr_tc) begin
            sw_en     <= '0;
            fault     <= 1'b1;
            fault_dom <= idx;
            state     <= ST_FAULT;
          end
        end

        ST_DN_SETTLE: begin
          if (tmr_tc) begin
            if (nb_dn.found) begin
              idx   <= IDX_W'(nb_dn.index);
              state <= ST_DN_CMD;
            end else begin
              state <= ST_OFF;
            end
          end
        end

        ST_FAULT: begin
          // fault_dom is deliberately left alone for post-mortem reads.
          if (clear_fault) begin
            fault <= 1'b0;
            state <= ST_OFF;
          end
        end

        default: begin
          sw_en <= '0;
          state <= ST_OFF;
        end
      endcase
    end
  end

  // Status flags are pure decodes of the state register.
  always_comb begin
    busy    = 1'b0;
    all_on  = 1'b0;
    all_off = 1'b0;
    case (state)
      ST_UP_CMD, ST_UP_WAIT, ST_UP_SETTLE,
      ST_DN_CMD, ST_DN_WAIT, ST_DN_SETTLE: busy    = 1'b1;
      ST_ON:                               all_on  = 1'b1;
      ST_OFF:                              all_off = 1'b1;
      default: begin
        busy    = 1'b0;
        all_on  = 1'b0;
        all_off = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pdn_domain_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pdn_domain_sequencer
// Bench for pdn_domain_sequencer with 6 domains, settle 16, timeout 256.
// A switch model echoes sw_en back on sw_ack after a programmable delay,
// with an optional stuck-off mask. Expected behaviour comes from timeline
// arithmetic: with P = 1 + ack delay + settle, the k-th domain of a
// sequence switches at 1 + k*P cycles after the request edge and the whole
// sequence finishes at n*P.
// ---------------------------------------------------------------------------
module tb_pdn_domain_sequencer;

  localparam int ND = 6;
  localparam int S  = 16;
  localparam int TO = 256;

  logic          clk;
  logic          rst;
  logic          pwr_up_req;
  logic          pwr_dn_req;
  logic [ND-1:0] domain_mask;
  logic [ND-1:0] sw_ack;
  logic          clear_fault;
  logic [ND-1:0] sw_en;
  logic          busy;
  logic          all_on;
  logic          all_off;
  logic          fault;
  logic [2:0]    fault_dom;

  int vectors    = 0;
  int miscompares = 0;

  int            ack_dly  = 3;
  logic [ND-1:0] stuck_lo = '0;
  logic [ND-1:0] en_hist [8];

  typedef struct {
    logic [ND-1:0] mask;
    int            dly;
    int            t_up;
    int            t_dn;
  } vec_t;

  vec_t tbl [6];

  pdn_domain_sequencer #(
    .NUM_DOMAINS    (ND),
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pwr_up_req  (pwr_up_req),
    .pwr_dn_req  (pwr_dn_req),
    .domain_mask (domain_mask),
    .sw_ack      (sw_ack),
    .clear_fault (clear_fault),
    .sw_en       (sw_en),
    .busy        (busy),
    .all_on      (all_on),
    .all_off     (all_off),
    .fault       (fault),
    .fault_dom   (fault_dom)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Switch model: an ack driven at the negedge after edge j reflects sw_en
  // as it was after edge j-(ack_dly-1), so it is first seen by the DUT
  // exactly ack_dly edges after the enable changed.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) en_hist[k] = '0;
    end else begin
      for (int k = 7; k > 0; k--) en_hist[k] = en_hist[k-1];
      en_hist[0] = sw_en;
    end
    sw_ack = en_hist[ack_dly-1] & ~stuck_lo;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Expected enables t cycles after the request edge of an up (or down)
  // sequence over mask m with step period p.
  function automatic logic [ND-1:0] model_en(input bit up, input logic [ND-1:0] m,
                                             input int t, input int p);
    logic [ND-1:0] e;
    int rank;
    e = '0;
    for (int i = 0; i < ND; i++) begin
      if (m[i]) begin
        rank = 0;
        if (up) begin
          for (int j = 0; j < i; j++) if (m[j]) rank++;
          e[i] = (t >= 1 + rank * p);
        end else begin
          for (int j = i + 1; j < ND; j++) if (m[j]) rank++;
          e[i] = (t < 1 + rank * p);
        end
      end
    end
    return e;
  endfunction

  // Issue one up or down request and follow it to completion, comparing the
  // whole output vector each cycle against the timeline model.
  task automatic run_phase(input bit up, input logic [ND-1:0] m, input int d,
                           input int t_exp, input string tag);
    int            p;
    int            t_done;
    bit            seen_bad;
    logic [31:0]   bad_act;
    logic [31:0]   bad_exp;
    logic [31:0]   obs;
    logic [31:0]   exp;
    p        = 1 + d + S;
    t_done   = -1;
    seen_bad = 1'b0;
    bad_act  = '0;
    bad_exp  = '0;
    @(negedge clk);
    if (up) begin
      domain_mask = m;
      pwr_up_req  = 1'b1;
    end else begin
      pwr_dn_req = 1'b1;
    end
    for (int t = 0; t <= t_exp + 3; t++) begin
      @(posedge clk);
      #1;
      if (t == 0) begin
        pwr_up_req  = 1'b0;
        pwr_dn_req  = 1'b0;
        domain_mask = ~m;
      end
      obs = {22'd0, sw_en, busy, all_on, all_off, fault};
      exp = {22'd0, model_en(up, m, t, p), (t < t_exp),
             (up && t >= t_exp), (!up && t >= t_exp), 1'b0};
      if (obs !== exp && !seen_bad) begin
        seen_bad = 1'b1;
        bad_act  = obs;
        bad_exp  = exp;
        $display("  %s first divergence at cycle %0d", tag, t);
      end
      if (t_done < 0 && (up ? all_on : all_off)) t_done = t;
    end
    check({tag, "_trace"}, bad_act, bad_exp);
    check({tag, "_done_cycle"}, 32'(t_done), 32'(t_exp));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [ND-1:0] rm;
    int            rd;
    int            t_done;
    bit            any_on;

    tbl[0] = '{6'b111111, 3, 120, 120};
    tbl[1] = '{6'b100101, 3,  60,  60};
    tbl[2] = '{6'b000001, 1,  18,  18};
    tbl[3] = '{6'b010000, 5,  22,  22};
    tbl[4] = '{6'b000000, 3,   0,   0};
    tbl[5] = '{6'b001010, 2,  38,  38};

    rst         = 1'b1;
    pwr_up_req  = 1'b0;
    pwr_dn_req  = 1'b0;
    domain_mask = '0;
    clear_fault = 1'b0;
    sw_ack      = '0;

    // Reset state
    #12;
    check("reset_outputs", {sw_en, busy, all_on, all_off, fault, fault_dom},
          {6'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0});
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    // Table-driven full up/down sequences
    for (int v = 0; v < 6; v++) begin
      ack_dly = tbl[v].dly;
      idle(4);
      run_phase(1'b1, tbl[v].mask, tbl[v].dly, tbl[v].t_up, $sformatf("tbl%0d_up", v));
      idle(2);
      run_phase(1'b0, tbl[v].mask, tbl[v].dly, tbl[v].t_dn, $sformatf("tbl%0d_dn", v));
    end

    // Randomised masks and ack delays
    for (int r = 0; r < 6; r++) begin
      rm      = ND'($urandom_range(0, 63));
      rd      = int'($urandom_range(1, 6));
      ack_dly = rd;
      idle(4 + int'($urandom_range(0, 5)));
      run_phase(1'b1, rm, rd, $countones(rm) * (1 + rd + S), $sformatf("rnd%0d_up", r));
      idle(int'($urandom_range(0, 5)));
      run_phase(1'b0, rm, rd, $countones(rm) * (1 + rd + S), $sformatf("rnd%0d_dn", r));
    end

    // Abort during UP_SETTLE of domain 2: unwind 2,1,0, never reach ON
    ack_dly = 3;
    idle(4);
    any_on = 1'b0;
    @(negedge clk);
    domain_mask = 6'b111111;
    pwr_up_req  = 1'b1;
    for (int t = 0; t <= 112; t++) begin
      @(posedge clk);
      #1;
      if (t == 0)  pwr_up_req = 1'b0;
      if (t == 50) pwr_dn_req = 1'b0;
      if (all_on) any_on = 1'b1;
      if (t == 50)  check("abort_t50_en", sw_en, 6'b000111);
      if (t == 51)  check("abort_t51_en", sw_en, 6'b000011);
      if (t == 70)  check("abort_t70_en", sw_en, 6'b000011);
      if (t == 71)  check("abort_t71_en", sw_en, 6'b000001);
      if (t == 91)  check("abort_t91_en", sw_en, 6'b000000);
      if (t == 109) check("abort_t109_off", all_off, 1'b0);
      if (t == 110) check("abort_t110_off", all_off, 1'b1);
      if (t == 49)  pwr_dn_req = 1'b1;
    end
    check("abort_never_on", any_on, 1'b0);

    // Abort in the UP_CMD cycle of domain 1: domain 1 never switches on
    idle(4);
    @(negedge clk);
    domain_mask = 6'b000011;
    pwr_up_req  = 1'b1;
    for (int t = 0; t <= 42; t++) begin
      @(posedge clk);
      #1;
      if (t == 0)  pwr_up_req = 1'b0;
      if (t == 21) pwr_dn_req = 1'b0;
      if (t == 21) check("abort_cmd_t21_en", sw_en, 6'b000001);
      if (t == 22) check("abort_cmd_t22_en", sw_en, 6'b000000);
      if (t == 41) check("abort_cmd_t41_off", all_off, 1'b1);
      if (t == 20) pwr_dn_req = 1'b1;
    end

    // Simultaneous requests in ON: down wins
    ack_dly = 1;
    idle(4);
    run_phase(1'b1, 6'b000001, 1, 18, "simul_up");
    @(negedge clk);
    pwr_up_req = 1'b1;
    pwr_dn_req = 1'b1;
    @(posedge clk);
    #1;
    pwr_up_req = 1'b0;
    pwr_dn_req = 1'b0;
    check("simul_on_state", {busy, all_on}, 2'b10);
    @(posedge clk);
    #1;
    check("simul_on_fall", sw_en, 6'b000000);
    t_done = -1;
    for (int t = 2; t <= 40; t++) begin
      @(posedge clk);
      #1;
      if (t_done < 0 && all_off) t_done = t;
    end
    check("simul_on_done_cycle", 32'(t_done), 32'd18);

    // Simultaneous requests in OFF: nothing happens
    @(negedge clk);
    domain_mask = 6'b111111;
    pwr_up_req  = 1'b1;
    pwr_dn_req  = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk);
      #1;
      pwr_up_req = 1'b0;
      pwr_dn_req = 1'b0;
      check($sformatf("simul_off_c%0d", t), {sw_en, busy, all_on, all_off},
            {6'b0, 1'b0, 1'b0, 1'b1});
    end

    // Timeout on domain 3
    ack_dly  = 3;
    stuck_lo = 6'b001000;
    idle(4);
    @(negedge clk);
    domain_mask = 6'b111111;
    pwr_up_req  = 1'b1;
    for (int t = 0; t <= 320; t++) begin
      @(posedge clk);
      #1;
      if (t == 0)   pwr_up_req = 1'b0;
      if (t == 61)  check("tmo_t61_en", sw_en, 6'b001111);
      if (t == 316) check("tmo_t316", {sw_en, fault}, {6'b001111, 1'b0});
      if (t == 317) check("tmo_t317", {sw_en, fault, busy, fault_dom},
                          {6'b000000, 1'b1, 1'b0, 3'd3});
    end
    @(negedge clk);
    pwr_up_req = 1'b1;
    @(posedge clk);
    #1;
    pwr_up_req = 1'b0;
    check("tmo_up_ignored", {sw_en, fault, all_off}, {6'b0, 1'b1, 1'b0});
    @(negedge clk);
    clear_fault = 1'b1;
    @(posedge clk);
    #1;
    clear_fault = 1'b0;
    check("tmo_cleared", {all_off, fault, fault_dom}, {1'b1, 1'b0, 3'd3});
    stuck_lo = '0;

    // Asynchronous reset in UP_WAIT of domain 3
    idle(4);
    @(negedge clk);
    domain_mask = 6'b111111;
    pwr_up_req  = 1'b1;
    for (int t = 0; t <= 62; t++) begin
      @(posedge clk);
      #1;
      if (t == 0) pwr_up_req = 1'b0;
    end
    check("arst_pre_en", sw_en, 6'b001111);
    #2;
    rst = 1'b1;
    #1;
    check("arst_immediate", {sw_en, busy, all_on, all_off}, {6'b0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Recovery after reset
    ack_dly = 2;
    idle(4);
    run_phase(1'b1, 6'b000100, 2, 19, "post_rst_up");
    run_phase(1'b0, 6'b000100, 2, 19, "post_rst_dn");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
